pipe_ctrl: RTL and testbench

//  Parametrised pipeline control unit; replaces hand-wired stall/flush assigns in the core top.

---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/pipe_ctrl_hold_chain.sv | 30 +++
 rtl/pipe_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Purpose : shared types and defaults for the pipeline control unit.
//   program_counter_t : redirect PC type used by the core
//   pipe_state_t      : control FSM states {RUN, FLUSH, REFILL}
//   PIPE_NUM_STAGES   : default number of controlled pipeline stages
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

   localparam int unsigned PIPE_NUM_STAGES = 8;
   localparam int unsigned PIPE_PC_WIDTH   = 32;

   typedef logic [PIPE_PC_WIDTH-1:0] program_counter_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FLUSH  = 2'd1,
      REFILL = 2'd2
   } pipe_state_t;

   // Width of the refill counter; it only has to reach NUM_STAGES-1.
   function automatic int unsigned refill_cnt_width(input int unsigned num_stages);
      refill_cnt_width = (num_stages > 32'd2) ? $clog2(num_stages) : 32'd1;
   endfunction

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_ctrl_hold_chain.sv
// -----------------------------------------------------------------------------
// pipe_hold_chain
// Purpose : combinational back-pressure chain. A stage holds when it is busy
//           itself, or when it is occupied and the stage after it holds.
//           An empty stage breaks the chain, so bubbles are squeezed out.
// Ports   :
//   i_stall_req [NUM_STAGES] : per-stage busy request
//   i_valid     [NUM_STAGES] : per-stage occupancy
//   o_hold      [NUM_STAGES] : per-stage hold (stage must keep its output)
// -----------------------------------------------------------------------------
module pipe_hold_chain
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned NUM_STAGES = PIPE_NUM_STAGES
) (
   input  logic [NUM_STAGES-1:0] i_stall_req,
   input  logic [NUM_STAGES-1:0] i_valid,
   output logic [NUM_STAGES-1:0] o_hold
);

   // Ripple the hold from writeback back towards fetch.
   always_comb begin
      o_hold               = '0;
      o_hold[NUM_STAGES-1] = i_stall_req[NUM_STAGES-1];
      for (int k = int'(NUM_STAGES) - 2; k >= 0; k--) begin
         o_hold[k] = i_stall_req[k] | (i_valid[k] & o_hold[k+1]);
      end
   end

endmodule : pipe_hold_chain

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Purpose : pipeline control unit. Tracks per-stage occupancy, derives stalls
//           through pipe_hold_chain, and sequences a registered flush + PC
//           redirect requested from writeback followed by a refill window.
// Optional: define PIPE_PERF_CNT_EN to add four 64-bit performance counters
//           (o_perf_cycles, o_perf_retired, o_perf_stalls, o_perf_flushes).
// Ports   :
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_fetch_valid     : fetch produced an instruction this cycle
//   i_stall_req [N]   : per-stage busy request
//   i_redirect        : writeback requests flush + redirect
//   i_redirect_pc     : redirect target
//   o_stall [N]       : per-stage hold
//   o_valid [N]       : per-stage shadow occupancy
//   o_flush           : one-cycle flush pulse
//   o_pc_alter        : load o_pc into the program counter (with o_flush)
//   o_pc              : latched redirect PC
//   o_refill          : high while in REFILL
//   o_retire          : last stage retires this cycle
// -----------------------------------------------------------------------------
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned NUM_STAGES = PIPE_NUM_STAGES,
   parameter int unsigned PC_WIDTH   = PIPE_PC_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_fetch_valid,
   input  logic [NUM_STAGES-1:0] i_stall_req,
   input  logic                  i_redirect,
   input  logic [PC_WIDTH-1:0]   i_redirect_pc,
   output logic [NUM_STAGES-1:0] o_stall,
   output logic [NUM_STAGES-1:0] o_valid,
   output logic                  o_flush,
   output logic                  o_pc_alter,
   output logic [PC_WIDTH-1:0]   o_pc,
   output logic                  o_refill,
`ifdef PIPE_PERF_CNT_EN
   output logic [63:0]           o_perf_cycles,
   output logic [63:0]           o_perf_retired,
   output logic [63:0]           o_perf_stalls,
   output logic [63:0]           o_perf_flushes,
`endif
   output logic                  o_retire
);

   localparam int unsigned CNT_W = refill_cnt_width(NUM_STAGES);

   pipe_state_t           state_q;
   logic [NUM_STAGES-1:0] valid_q;
   logic [NUM_STAGES-1:0] valid_d;
   logic [NUM_STAGES-1:0] hold_s;
   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_d;
   logic                  flush_q;
   logic                  refill_q;
   logic [PC_WIDTH-1:0]   pc_q;
   logic                  refill_exit_s;
   logic                  retire_s;

   pipe_hold_chain #(
      .NUM_STAGES (NUM_STAGES)
   ) u_hold_chain (
      .i_stall_req (i_stall_req),
      .i_valid     (valid_q),
      .o_hold      (hold_s)
   );

   // Occupancy advance: held stages keep their slot, others take the
   // predecessor's instruction only if the predecessor is not held.
   always_comb begin
      valid_d    = valid_q;
      valid_d[0] = hold_s[0] ? valid_q[0] : i_fetch_valid;
      for (int k = 1; k < int'(NUM_STAGES); k++) begin
         valid_d[k] = hold_s[k] ? valid_q[k] : (valid_q[k-1] & ~hold_s[k-1]);
      end
   end

   // Refill ends once the window has covered the pipe depth, or earlier if
   // an instruction already reaches the last stage.
   always_comb begin
      cnt_d         = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      refill_exit_s = (cnt_d == CNT_W'(NUM_STAGES - 1)) | valid_d[NUM_STAGES-1];
   end

   assign retire_s = valid_q[NUM_STAGES-1] & ~hold_s[NUM_STAGES-1];

   // Control FSM with occupancy registers and registered flush/refill flags.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= RUN;
         valid_q  <= '0;
         cnt_q    <= '0;
         flush_q  <= 1'b0;
         refill_q <= 1'b0;
         pc_q     <= '0;
      end else begin
         case (state_q)
            RUN: begin
               valid_q <= valid_d;
               if (i_redirect) begin
                  state_q <= FLUSH;
                  pc_q    <= i_redirect_pc;
                  flush_q <= 1'b1;
               end
            end
            FLUSH: begin
               // Any redirect seen here comes from a stage being flushed.
               valid_q  <= '0;
               cnt_q    <= '0;
               flush_q  <= 1'b0;
               refill_q <= 1'b1;
               state_q  <= REFILL;
            end
            REFILL: begin
               valid_q <= valid_d;
               if (i_redirect) begin
                  state_q  <= FLUSH;
                  pc_q     <= i_redirect_pc;
                  flush_q  <= 1'b1;
                  refill_q <= 1'b0;
               end else if (refill_exit_s) begin
                  state_q  <= RUN;
                  refill_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: begin
               state_q  <= RUN;
               valid_q  <= '0;
               cnt_q    <= '0;
               flush_q  <= 1'b0;
               refill_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef PIPE_PERF_CNT_EN
   logic [63:0] perf_cycles_q;
   logic [63:0] perf_retired_q;
   logic [63:0] perf_stalls_q;
   logic [63:0] perf_flushes_q;
   logic        flush_enter_s;

   assign flush_enter_s = i_redirect & ((state_q == RUN) | (state_q == REFILL));

   // Free-running 64-bit event counters; they wrap naturally.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         perf_cycles_q  <= 64'd0;
         perf_retired_q <= 64'd0;
         perf_stalls_q  <= 64'd0;
         perf_flushes_q <= 64'd0;
      end else begin
         perf_cycles_q <= perf_cycles_q + 64'd1;
         if (retire_s) begin
            perf_retired_q <= perf_retired_q + 64'd1;
         end
         if (hold_s[0] && (state_q == RUN)) begin
            perf_stalls_q <= perf_stalls_q + 64'd1;
         end
         if (flush_enter_s) begin
            perf_flushes_q <= perf_flushes_q + 64'd1;
         end
      end
   end

   assign o_perf_cycles  = perf_cycles_q;
   assign o_perf_retired = perf_retired_q;
   assign o_perf_stalls  = perf_stalls_q;
   assign o_perf_flushes = perf_flushes_q;
`endif

   assign o_stall    = hold_s;
   assign o_valid    = valid_q;
   assign o_flush    = flush_q;
   assign o_pc_alter = flush_q;
   assign o_pc       = pc_q;
   assign o_refill   = refill_q;
   assign o_retire   = retire_s;

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Purpose : directed self-checking bench for pipe_ctrl (8 stages, 32-bit PC).
//           Inputs change 1 ns after the rising edge; outputs are sampled
//           2 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

   logic        i_clk;
   logic        i_rst;
   logic        i_fetch_valid;
   logic [7:0]  i_stall_req;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic [7:0]  o_stall;
   logic [7:0]  o_valid;
   logic        o_flush;
   logic        o_pc_alter;
   logic [31:0] o_pc;
   logic        o_refill;
   logic        o_retire;
`ifdef PIPE_PERF_CNT_EN
   logic [63:0] o_perf_cycles;
   logic [63:0] o_perf_retired;
   logic [63:0] o_perf_stalls;
   logic [63:0] o_perf_flushes;
`endif

   int checks = 0;
   int errors = 0;

   pipe_ctrl #(
      .NUM_STAGES (8),
      .PC_WIDTH   (32)
   ) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_fetch_valid (i_fetch_valid),
      .i_stall_req   (i_stall_req),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_stall       (o_stall),
      .o_valid       (o_valid),
      .o_flush       (o_flush),
      .o_pc_alter    (o_pc_alter),
      .o_pc          (o_pc),
      .o_refill      (o_refill),
`ifdef PIPE_PERF_CNT_EN
      .o_perf_cycles  (o_perf_cycles),
      .o_perf_retired (o_perf_retired),
      .o_perf_stalls  (o_perf_stalls),
      .o_perf_flushes (o_perf_flushes),
`endif
      .o_retire      (o_retire)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp_v;
      logic [4:0] pat;

      i_rst         = 1'b1;
      i_fetch_valid = 1'b0;
      i_stall_req   = 8'h00;
      i_redirect    = 1'b0;
      i_redirect_pc = 32'h0;

      // Reset state
      tick();
      tick();
      settle();
      chk("rst_valid",    64'(o_valid),    64'h0);
      chk("rst_flush",    64'(o_flush),    64'h0);
      chk("rst_pc_alter", 64'(o_pc_alter), 64'h0);
      chk("rst_pc",       64'(o_pc),       64'h0);
      chk("rst_refill",   64'(o_refill),   64'h0);
      chk("rst_retire",   64'(o_retire),   64'h0);
      chk("rst_stall",    64'(o_stall),    64'h0);

      // Fill an empty pipe with one instruction per cycle
      i_rst         = 1'b0;
      i_fetch_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         settle();
         exp_v = 8'((16'd1 << (i + 1)) - 16'd1);
         chk("fill_valid",  64'(o_valid),  64'(exp_v));
         chk("fill_retire", 64'(o_retire), (i == 7) ? 64'h1 : 64'h0);
      end

      // Full pipe, stage 5 busy for three cycles: 6-7 drain, retire twice
      i_stall_req = 8'h20;
      settle();
      chk("st5_a_stall",  64'(o_stall),  64'h3F);
      chk("st5_a_retire", 64'(o_retire), 64'h1);
      tick();
      settle();
      chk("st5_b_valid",  64'(o_valid),  64'hBF);
      chk("st5_b_stall",  64'(o_stall),  64'h3F);
      chk("st5_b_retire", 64'(o_retire), 64'h1);
      tick();
      settle();
      chk("st5_c_valid",  64'(o_valid),  64'h3F);
      chk("st5_c_stall",  64'(o_stall),  64'h3F);
      chk("st5_c_retire", 64'(o_retire), 64'h0);

      // Release and drain completely with no new fetches
      i_stall_req   = 8'h00;
      i_fetch_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         settle();
         exp_v = 8'(16'h3F << (i + 1));
         chk("drain_valid", 64'(o_valid), 64'(exp_v));
      end

      // Build valid = 0b0001_0011 by fetching 1,0,0,1,1
      pat = 5'b11001;
      for (int j = 0; j < 5; j++) begin
         i_fetch_valid = pat[j];
         tick();
      end
      settle();
      chk("bub_valid0", 64'(o_valid), 64'h13);

      // Stage 4 busy: only stage 4 stalls, the 0/1 pair closes the bubble
      i_fetch_valid = 1'b0;
      i_stall_req   = 8'h10;
      settle();
      chk("bub_stall0", 64'(o_stall), 64'h10);
      tick();
      settle();
      chk("bub_valid1", 64'(o_valid), 64'h16);
      chk("bub_stall1", 64'(o_stall), 64'h10);
      tick();
      settle();
      chk("bub_valid2", 64'(o_valid), 64'h1C);
      chk("bub_stall2", 64'(o_stall), 64'h1C);

      // Redirect from RUN
      i_stall_req   = 8'h00;
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h8000_0100;
      tick();
      i_redirect = 1'b0;
      settle();
      chk("rd_flush",    64'(o_flush),    64'h1);
      chk("rd_pc_alter", 64'(o_pc_alter), 64'h1);
      chk("rd_pc",       64'(o_pc),       64'h8000_0100);
      chk("rd_valid",    64'(o_valid),    64'h38);
      chk("rd_refill0",  64'(o_refill),   64'h0);
      tick();
      settle();
      chk("rd_flush_end", 64'(o_flush),  64'h0);
      chk("rd_valid_clr", 64'(o_valid),  64'h0);
      chk("rd_refill1",   64'(o_refill), 64'h1);
      for (int i = 0; i < 6; i++) begin
         tick();
         settle();
         chk("rd_refill_win", 64'(o_refill), 64'h1);
      end
      tick();
      settle();
      chk("rd_refill_end", 64'(o_refill), 64'h0);

      // Redirect held two cycles: one flush, PC from the first
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h1111_0000;
      tick();
      i_redirect_pc = 32'h2222_0000;
      settle();
      chk("dbl_flush", 64'(o_flush), 64'h1);
      chk("dbl_pc",    64'(o_pc),    64'h1111_0000);
      tick();
      i_redirect = 1'b0;
      settle();
      chk("dbl_flush2", 64'(o_flush),  64'h0);
      chk("dbl_refill", 64'(o_refill), 64'h1);
      chk("dbl_pc2",    64'(o_pc),     64'h1111_0000);
      tick();
      settle();
      chk("dbl_noflush", 64'(o_flush), 64'h0);

      // Redirect during REFILL is taken with the new PC
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h3333_0000;
      tick();
      i_redirect = 1'b0;
      settle();
      chk("rf_flush",  64'(o_flush),  64'h1);
      chk("rf_pc",     64'(o_pc),     64'h3333_0000);
      chk("rf_refill", 64'(o_refill), 64'h0);
      tick();
      settle();
      chk("rf_refill2", 64'(o_refill), 64'h1);
      chk("rf_flush2",  64'(o_flush),  64'h0);

      // Reset in the middle of REFILL
      i_fetch_valid = 1'b1;
      tick();
      settle();
      chk("rr_valid_pre", 64'(o_valid), 64'h01);
      i_rst         = 1'b1;
      i_fetch_valid = 1'b0;
      tick();
      settle();
      chk("rr_valid",  64'(o_valid),    64'h0);
      chk("rr_refill", 64'(o_refill),   64'h0);
      chk("rr_pc",     64'(o_pc),       64'h0);
      chk("rr_flush",  64'(o_flush),    64'h0);
      chk("rr_alter",  64'(o_pc_alter), 64'h0);
      chk("rr_retire", 64'(o_retire),   64'h0);
      i_rst = 1'b0;

`ifdef PIPE_PERF_CNT_EN
      // 100 cycles after reset containing two flushes
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      for (int c = 0; c < 100; c++) begin
         i_redirect    = (c == 10) || (c == 50);
         i_redirect_pc = 32'h0000_4000;
         tick();
      end
      i_redirect = 1'b0;
      settle();
      chk("perf_cycles",  o_perf_cycles,  64'd100);
      chk("perf_flushes", o_perf_flushes, 64'd2);
      chk("perf_retired", o_perf_retired, 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pipe_ctrl
